// File: rtl/result_writeback.sv
// Drains one finished N1xN2 result tile per handshake into the row-major C buffer.
// Optional macro WB_RELU_EN: negative elements are written as zero.
module result_writeback #(
    parameter int N1           = 4,
    parameter int N2           = 4,
    parameter int MATRIXSIZE_W = 16,
    parameter int DATA_W       = 32,
    parameter int ADDR_W_C     = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [MATRIXSIZE_W-1:0]   M3,
    input  logic [MATRIXSIZE_W-1:0]   M3dN2,
    input  logic [MATRIXSIZE_W-1:0]   M1xM3dN1xN2,
    input  logic                      start,
    input  logic                      tile_valid,
    input  logic [N1*N2*DATA_W-1:0]   tile_data,
    output logic                      tile_ready,
    output logic                      wr_en,
    output logic [ADDR_W_C-1:0]       wr_addr,
    output logic [DATA_W-1:0]         wr_data,
    output logic                      done,
    output logic [1:0]                state_dbg_o
);

    localparam int MW = MATRIXSIZE_W;
    localparam int NE = N1 * N2;
    localparam int EW = (NE > 1) ? $clog2(NE) : 1;
    localparam int JW = (N2 > 1) ? $clog2(N2) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [NE*DATA_W-1:0]    buf_q, buf_d;
    logic [MW-1:0]           tiles_q, tiles_d;
    logic [MW-1:0]           cb_q, cb_d;
    logic [MW-1:0]           row_base_q, row_base_d;
    logic [MW-1:0]           col_base_q, col_base_d;
    logic [MW-1:0]           row_off_q, row_off_d;
    logic [EW-1:0]           e_q, e_d;
    logic [JW-1:0]           j_q, j_d;
    logic                    wr_en_q, wr_en_d;
    logic [ADDR_W_C-1:0]     wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]       wr_data_q, wr_data_d;

    logic [DATA_W-1:0]       elems [NE];

    for (genvar g = 0; g < NE; g++) begin : g_el
        assign elems[g] = buf_q[g*DATA_W +: DATA_W];
    end

    function automatic logic [DATA_W-1:0] shape(input logic [DATA_W-1:0] x);
`ifdef WB_RELU_EN
        return x[DATA_W-1] ? '0 : x;
`else
        return x;
`endif
    endfunction

    // Handshake: a tile transfers on a rising edge where tile_valid and
    // tile_ready are both high; the producer holds tile_valid/tile_data until then.
    assign tile_ready  = (state_q == IDLE);
    assign done        = (state_q == DONE);
    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign state_dbg_o = state_q;

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        tiles_d    = tiles_q;
        cb_d       = cb_q;
        row_base_d = row_base_q;
        col_base_d = col_base_q;
        row_off_d  = row_off_q;
        e_d        = e_q;
        j_d        = j_q;
        wr_en_d    = wr_en_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    tiles_d    = '0;
                    cb_d       = '0;
                    row_base_d = '0;
                    col_base_d = '0;
                    row_off_d  = '0;
                    e_d        = '0;
                    j_d        = '0;
                end else if (tiles_q == M1xM3dN1xN2) begin
                    state_d = DONE;
                end else if (tile_valid) begin
                    // Element (0,0) goes out straight from the input bus.
                    buf_d     = tile_data;
                    e_d       = '0;
                    j_d       = '0;
                    row_off_d = '0;
                    wr_en_d   = 1'b1;
                    wr_addr_d = ADDR_W_C'(row_base_q + col_base_q);
                    wr_data_d = shape(tile_data[DATA_W-1:0]);
                    state_d   = DRAIN;
                end
            end
            DRAIN: begin
                if (e_q == EW'(NE - 1)) begin
                    wr_en_d = 1'b0;
                    tiles_d = tiles_q + MW'(1);
                    if (cb_q == M3dN2 - MW'(1)) begin
                        cb_d       = '0;
                        col_base_d = '0;
                        row_base_d = row_base_q + MW'(N1) * M3;
                    end else begin
                        cb_d       = cb_q + MW'(1);
                        col_base_d = col_base_q + MW'(N2);
                    end
                    state_d = (tiles_d == M1xM3dN1xN2) ? DONE : IDLE;
                end else begin
                    e_d = e_q + EW'(1);
                    if (j_q == JW'(N2 - 1)) begin
                        j_d       = '0;
                        row_off_d = row_off_q + M3;
                    end else begin
                        j_d = j_q + JW'(1);
                    end
                    wr_addr_d = ADDR_W_C'(row_base_q + row_off_d + col_base_q + MW'(j_d));
                    wr_data_d = shape(elems[e_d]);
                end
            end
            DONE: begin
                if (start) begin
                    tiles_d    = '0;
                    cb_d       = '0;
                    row_base_d = '0;
                    col_base_d = '0;
                    row_off_d  = '0;
                    e_d        = '0;
                    j_d        = '0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            buf_q      <= '0;
            tiles_q    <= '0;
            cb_q       <= '0;
            row_base_q <= '0;
            col_base_q <= '0;
            row_off_q  <= '0;
            e_q        <= '0;
            j_q        <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            tiles_q    <= tiles_d;
            cb_q       <= cb_d;
            row_base_q <= row_base_d;
            col_base_q <= col_base_d;
            row_off_q  <= row_off_d;
            e_q        <= e_d;
            j_q        <= j_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

endmodule

// File: tb/tb_result_writeback.sv
// Directed bench for result_writeback with N1=N2=2 and a 4x4 C buffer (2x2 tiles).
module tb_result_writeback;

    logic         clk;
    logic         rst;
    logic [15:0]  M3;
    logic [15:0]  M3dN2;
    logic [15:0]  M1xM3dN1xN2;
    logic         start;
    logic         tile_valid;
    logic [127:0] tile_data;
    logic         tile_ready;
    logic         wr_en;
    logic [11:0]  wr_addr;
    logic [31:0]  wr_data;
    logic         done;
    logic [1:0]   state_dbg;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_count = 0;

    logic [43:0] exp_q[$];
    logic [11:0] exp_addr [16];

    result_writeback #(
        .N1(2), .N2(2), .MATRIXSIZE_W(16), .DATA_W(32), .ADDR_W_C(12)
    ) dut (
        .clk(clk), .rst(rst), .M3(M3), .M3dN2(M3dN2), .M1xM3dN1xN2(M1xM3dN1xN2),
        .start(start), .tile_valid(tile_valid), .tile_data(tile_data),
        .tile_ready(tile_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .done(done), .state_dbg_o(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [127:0] tile_word(input int t);
        logic [127:0] w;
        for (int e = 0; e < 4; e++) w[e*32 +: 32] = 32'(16 * t + e);
        return w;
    endfunction

    task automatic push_tile(input logic [127:0] expd, input int t);
        for (int e = 0; e < 4; e++)
            exp_q.push_back({exp_addr[4*(t%4)+e], expd[e*32 +: 32]});
    endtask

    // Scoreboard: every write is matched against the head of exp_q.
    always @(posedge clk) begin
        logic [43:0] ent;
        #1;
        if (wr_en) begin
            wr_count++;
            if (exp_q.size() == 0) begin
                check("unexpected_wr", wr_en, 1'b0);
            end else begin
                ent = exp_q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(ent[43:32]));
                check("wr_data", wr_data, ent[31:0]);
            end
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Called #1 after an edge with the DUT in IDLE; returns in the cycle after the tile drained.
    task automatic send_tile(input logic [127:0] data, input logic [127:0] expd, input int t);
        check("ready_before_tile", tile_ready, 1'b1);
        tile_valid = 1'b1;
        tile_data  = data;
        push_tile(expd, t);
        @(posedge clk); #1;
        tile_valid = 1'b0;
        check("accept_latency", wr_en, 1'b1);
        for (int k = 0; k < 4; k++) begin
            check("ready_low_in_drain", tile_ready, 1'b0);
            @(posedge clk); #1;
        end
    endtask

    task automatic stream_held();
        int   acc = 0;
        int   low = 0;
        int   run = 0;
        int   cyc = 0;
        logic prev_wr = 1'b0;
        logic lat_pending = 1'b0;
        tile_valid = 1'b1;
        while (!done && cyc < 100) begin
            if (lat_pending) begin
                check("held_accept_latency", wr_en, 1'b1);
                lat_pending = 1'b0;
            end
            if (wr_en) run++;
            else if (run != 0) begin
                check("wr_en_run", run, 4);
                run = 0;
            end
            if (tile_ready) begin
                if (acc > 0) check("ready_low_cycles", low, 4);
                low = 0;
                if (acc < 4) begin
                    tile_data = tile_word(acc);
                    push_tile(tile_word(acc), acc);
                    acc++;
                    lat_pending = 1'b1;
                end
            end else begin
                low++;
            end
            prev_wr = wr_en;
            @(posedge clk); #1;
            cyc++;
        end
        tile_valid = 1'b0;
        check("job_done", done, 1'b1);
        check("done_after_last_wr", prev_wr, 1'b1);
        check("wr_en_run_last", run, 4);
        check("tiles_accepted", acc, 4);
        check("exp_q_empty", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int wr_before;
        exp_addr = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
        rst = 1'b1; start = 1'b0; tile_valid = 1'b0; tile_data = '0;
        M3 = 16'd4; M3dN2 = 16'd2; M1xM3dN1xN2 = 16'd4;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_tile_ready", tile_ready, 1'b1);
        check("rst_wr_en", wr_en, 1'b0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", wr_data, 32'd0);
        check("rst_done", done, 1'b0);
        check("rst_state", 32'(state_dbg), 32'd0);

        // Full job, tile_valid held high throughout.
        do_start();
        stream_held();
        check("done_state", 32'(state_dbg), 32'd2);
        @(posedge clk); #1;
        check("done_holds", done, 1'b1);
        check("done_ready_low", tile_ready, 1'b0);

        // Reset after the second write of tile1, then replay tile0.
        do_start();
        check("restart_done_clear", done, 1'b0);
        send_tile(tile_word(0), tile_word(0), 0);
        tile_valid = 1'b1;
        tile_data  = tile_word(1);
        push_tile(tile_word(1), 1);
        @(posedge clk); #1;
        tile_valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("midrst_wr_en", wr_en, 1'b0);
        check("midrst_tile_ready", tile_ready, 1'b1);
        check("midrst_done", done, 1'b0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        do_start();
        send_tile(tile_word(0), tile_word(0), 0);
        check("replay_exp_empty", exp_q.size(), 0);

        // Zero-tile job finishes without writing, then a normal job follows.
        M1xM3dN1xN2 = 16'd0;
        wr_before = wr_count;
        do_start();
        @(posedge clk); #1;
        check("zero_done", done, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("zero_no_writes", wr_count - wr_before, 0);
        M1xM3dN1xN2 = 16'd4;
        do_start();
        check("after_zero_done_clear", done, 1'b0);
        for (int t = 0; t < 4; t++) send_tile(tile_word(t), tile_word(t), t);
        check("after_zero_done", done, 1'b1);

        // Sign handling.
        do_start();
`ifdef WB_RELU_EN
        send_tile({32'd3, 32'h8000_0000, 32'd7, 32'hFFFF_FFFB},
                  {32'd3, 32'h0000_0000, 32'd7, 32'h0000_0000}, 0);
`else
        send_tile({32'd3, 32'h8000_0000, 32'd7, 32'hFFFF_FFFB},
                  {32'd3, 32'h8000_0000, 32'd7, 32'hFFFF_FFFB}, 0);
`endif

        // start pulsed mid-drain is ignored; tile1 continues the address sequence.
        do_start();
        tile_valid = 1'b1;
        tile_data  = tile_word(0);
        push_tile(tile_word(0), 0);
        @(posedge clk); #1;
        tile_valid = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("drain_start_wr_en", wr_en, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("drain_start_idle", tile_ready, 1'b1);
        check("drain_start_no_done", done, 1'b0);
        send_tile(tile_word(1), tile_word(1), 1);
        check("drain_start_exp_empty", exp_q.size(), 0);

        repeat (2) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
